counting_seq_gen: RTL and testbench

Sequence generator that drives the 2-bit `num` symbol stream consumed by the `counting` pattern detector. On request it emits runs of symbol 1, then 2, then 3, with programmable run lengths, then returns to 0. It tracks the detector's expected state in a shadow FSM and checks the detector's `ans` output every cycle, logging mismatches. It sits on the transmit side of the detector link in the self-test path.

---
 rtl/counting_seq_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_counting_seq_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counting_seq_gen.sv
// Symbol stream generator for the counting pattern detector.
// Emits programmable runs of symbols 1, 2 and 3, then returns to 0.
// A shadow copy of the detector FSM predicts its ans output.
// Any disagreement with the returned ans is flagged and counted.
module counting_seq_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len1_i,
  input  logic [CNT_W-1:0] len2_i,
  input  logic [CNT_W-1:0] len3_i,
  input  logic             ans_in_i,
  output logic [1:0]       num_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ans_exp_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT1,
    EMIT2,
    EMIT3,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] runCnt_q, runCnt_d;
  logic [CNT_W-1:0] len1_q, len1_d;
  logic [CNT_W-1:0] len2_q, len2_d;
  logic [CNT_W-1:0] len3_q, len3_d;
  logic [1:0]       num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       shadow_q, shadow_d;
  logic             err_q, err_d;
  logic [7:0]       errCnt_q, errCnt_d;
  logic             accept;
  logic             ansExp;
  logic             mismatch;

  // Main sequencing: choose the next phase, skipping any phase whose length
  // is zero, and load the run counter with length-1 on entry to a phase.
  always_comb begin
    state_d  = state_q;
    runCnt_d = runCnt_q;
    len1_d   = len1_q;
    len2_d   = len2_q;
    len3_d   = len3_q;
    accept   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          accept = 1'b1;
          len1_d = len1_i;
          len2_d = len2_i;
          len3_d = len3_i;
          if (len1_i != '0) begin
            state_d  = EMIT1;
            runCnt_d = len1_i - RUN_ONE;
          end else if (len2_i != '0) begin
            state_d  = EMIT2;
            runCnt_d = len2_i - RUN_ONE;
          end else if (len3_i != '0) begin
            state_d  = EMIT3;
            runCnt_d = len3_i - RUN_ONE;
          end else begin
            state_d = DONE;
          end
        end
      end
      EMIT1: begin
        if (runCnt_q != '0) begin
          runCnt_d = runCnt_q - RUN_ONE;
        end else if (len2_q != '0) begin
          state_d  = EMIT2;
          runCnt_d = len2_q - RUN_ONE;
        end else if (len3_q != '0) begin
          state_d  = EMIT3;
          runCnt_d = len3_q - RUN_ONE;
        end else begin
          state_d = DONE;
        end
      end
      EMIT2: begin
        if (runCnt_q != '0) begin
          runCnt_d = runCnt_q - RUN_ONE;
        end else if (len3_q != '0) begin
          state_d  = EMIT3;
          runCnt_d = len3_q - RUN_ONE;
        end else begin
          state_d = DONE;
        end
      end
      EMIT3: begin
        if (runCnt_q != '0) begin
          runCnt_d = runCnt_q - RUN_ONE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered,
  // aligned with the state they describe.
  always_comb begin
    num_d  = 2'd0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      EMIT1: begin
        num_d  = 2'd1;
        busy_d = 1'b1;
      end
      EMIT2: begin
        num_d  = 2'd2;
        busy_d = 1'b1;
      end
      EMIT3: begin
        num_d  = 2'd3;
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        num_d = 2'd0;
      end
    endcase
  end

  // Shadow of the detector: it advances on the symbol currently on the link,
  // just as the detector does, so ans_exp lags num by one cycle.
  always_comb begin
    shadow_d = 2'd0;
    case (shadow_q)
      2'd0: shadow_d = (num_q == 2'd1) ? 2'd1 : 2'd0;
      2'd1: begin
        if (num_q == 2'd1)      shadow_d = 2'd1;
        else if (num_q == 2'd2) shadow_d = 2'd2;
        else                    shadow_d = 2'd0;
      end
      2'd2: shadow_d = num_q;
      2'd3: begin
        if (num_q == 2'd1)      shadow_d = 2'd1;
        else if (num_q == 2'd3) shadow_d = 2'd3;
        else                    shadow_d = 2'd0;
      end
      default: shadow_d = 2'd0;
    endcase
  end

  assign ansExp   = (shadow_q == 2'd3);
  assign mismatch = (ans_in_i != ansExp);

  // Error logging: a newly accepted burst clears the log and takes priority
  // over a mismatch seen in that same cycle; the counter saturates at 255.
  always_comb begin
    err_d    = err_q;
    errCnt_d = errCnt_q;
    if (accept) begin
      err_d    = 1'b0;
      errCnt_d = 8'd0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (errCnt_q != 8'hFF) begin
        errCnt_d = errCnt_q + 8'd1;
      end
    end
  end

  // State and output registers with synchronous active-low reset; a reset
  // mid-burst simply drops back to idle without a done pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      runCnt_q <= '0;
      len1_q   <= '0;
      len2_q   <= '0;
      len3_q   <= '0;
      num_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= 2'd0;
      err_q    <= 1'b0;
      errCnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      runCnt_q <= runCnt_d;
      len1_q   <= len1_d;
      len2_q   <= len2_d;
      len3_q   <= len3_d;
      num_q    <= num_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign num_o     = num_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ans_exp_o = ansExp;
  assign err_o     = err_q;
  assign err_cnt_o = errCnt_q;

endmodule

// File: tb/tb_counting_seq_gen.sv
// Testbench for counting_seq_gen: a behavioural counting detector closes the
// loop on ans, and per-cycle expectations are queued when a burst is launched.
module tb_counting_seq_gen;

  localparam int CNT_W = 4;

  typedef struct {
    logic [1:0] num;
    logic       busy;
    logic       done;
    logic       ans;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] len2;
  logic [CNT_W-1:0] len3;
  logic             ansIn;
  logic [1:0]       num;
  logic             busy;
  logic             done;
  logic             ansExp;
  logic             err;
  logic [7:0]       errCnt;

  logic [1:0] detState;
  logic       tieZero;
  exp_t       expQ[$];
  int         checks;
  int         failures;

  counting_seq_gen #(.CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .len1_i    (len1),
    .len2_i    (len2),
    .len3_i    (len3),
    .ans_in_i  (ansIn),
    .num_o     (num),
    .busy_o    (busy),
    .done_o    (done),
    .ans_exp_o (ansExp),
    .err_o     (err),
    .err_cnt_o (errCnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counting detector transition table.
  function automatic logic [1:0] detNext(input logic [1:0] s, input logic [1:0] n);
    case (s)
      2'd0: detNext = (n == 2'd1) ? 2'd1 : 2'd0;
      2'd1: detNext = (n == 2'd1) ? 2'd1 : ((n == 2'd2) ? 2'd2 : 2'd0);
      2'd2: detNext = n;
      default: detNext = (n == 2'd1) ? 2'd1 : ((n == 2'd3) ? 2'd3 : 2'd0);
    endcase
  endfunction

  // The detector on the far side of the link, optionally overridden to 0.
  always @(posedge clk) begin
    if (!rst_n) detState <= 2'd0;
    else        detState <= detNext(detState, num);
  end

  assign ansIn = tieZero ? 1'b0 : (detState == 2'd3);

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pushIdle(input int n);
    exp_t e;
    e.num = 2'd0; e.busy = 1'b0; e.done = 1'b0; e.ans = 1'b0; e.err = 1'b0; e.cnt = 8'd0;
    for (int i = 0; i < n; i++) expQ.push_back(e);
  endtask

  // Compare one cycle of DUT output (mid-cycle) against the queue head.
  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_queue: observed empty expected an entry", tag);
    end else begin
      e = expQ.pop_front();
      checkField({tag, "_num"},  {6'd0, num},    {6'd0, e.num});
      checkField({tag, "_busy"}, {7'd0, busy},   {7'd0, e.busy});
      checkField({tag, "_done"}, {7'd0, done},   {7'd0, e.done});
      checkField({tag, "_ans"},  {7'd0, ansExp}, {7'd0, e.ans});
      checkField({tag, "_err"},  {7'd0, err},    {7'd0, e.err});
      checkField({tag, "_cnt"},  errCnt,         e.cnt);
    end
  endtask

  // Queue expectations for cycles 1..min(L+2, maxCycles), then launch the
  // burst so that it is accepted at the next rising edge (edge 0).
  task automatic applyStimulus(input int l1, input int l2, input int l3,
                               input bit tie, input int maxCycles);
    logic [1:0] sym[$];
    logic [1:0] s;
    logic [1:0] prevNum;
    logic       prevAns;
    logic       errM;
    int         cntM;
    int         total;
    exp_t       e;
    for (int i = 0; i < l1; i++) sym.push_back(2'd1);
    for (int i = 0; i < l2; i++) sym.push_back(2'd2);
    for (int i = 0; i < l3; i++) sym.push_back(2'd3);
    total   = sym.size();
    s       = 2'd0;
    prevNum = 2'd0;
    prevAns = 1'b0;
    errM    = 1'b0;
    cntM    = 0;
    for (int c = 1; c <= total + 2 && c <= maxCycles; c++) begin
      e.num  = (c <= total) ? sym[c-1] : 2'd0;
      e.busy = (c <= total);
      e.done = (c == total + 1);
      s      = detNext(s, prevNum);
      e.ans  = (s == 2'd3);
      if (c >= 2 && tie && prevAns) begin
        errM = 1'b1;
        if (cntM < 255) cntM++;
      end
      e.err = errM;
      e.cnt = 8'(cntM);
      expQ.push_back(e);
      prevNum = e.num;
      prevAns = e.ans;
    end
    @(negedge clk);
    tieZero = tie;
    len1    = CNT_W'(l1);
    len2    = CNT_W'(l2);
    len3    = CNT_W'(l3);
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    len1     = '0;
    len2     = '0;
    len3     = '0;
    tieZero  = 1'b0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    pushIdle(1);
    checkOutput("reset");
    rst_n = 1'b1;

    $display("[TB] burst 2,1,3");
    applyStimulus(2, 1, 3, 1'b0, 100);
    repeat (8) checkOutput("b213");

    $display("[TB] burst 0,2,2");
    applyStimulus(0, 2, 2, 1'b0, 100);
    repeat (6) checkOutput("b022");

    $display("[TB] burst 3,2,0");
    applyStimulus(3, 2, 0, 1'b0, 100);
    repeat (7) checkOutput("b320");

    $display("[TB] burst 0,0,0");
    applyStimulus(0, 0, 0, 1'b0, 100);
    repeat (2) checkOutput("b000");

    $display("[TB] burst 1,1,1 with ans tied low");
    applyStimulus(1, 1, 1, 1'b1, 100);
    repeat (5) checkOutput("tie0");

    $display("[TB] burst 1,1,1 clears the error log");
    applyStimulus(1, 1, 1, 1'b0, 100);
    repeat (5) checkOutput("clear");

    $display("[TB] start while busy is ignored");
    applyStimulus(1, 1, 1, 1'b0, 100);
    checkOutput("ign");
    checkOutput("ign");
    len1  = CNT_W'(5);
    len2  = CNT_W'(5);
    len3  = CNT_W'(5);
    start = 1'b1;
    checkOutput("ign");
    start = 1'b0;
    repeat (2) checkOutput("ign");

    $display("[TB] maximum-length burst 15,15,15");
    applyStimulus(15, 15, 15, 1'b0, 100);
    repeat (47) checkOutput("max");

    $display("[TB] reset during a 4,4,4 burst");
    applyStimulus(4, 4, 4, 1'b0, 3);
    checkOutput("rstmid");
    checkOutput("rstmid");
    @(posedge clk);
    #1 rst_n = 1'b0;
    checkOutput("rstmid");
    pushIdle(6);
    checkOutput("rstmid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) checkOutput("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
